execute_stage: RTL and testbench

Execute (E) stage of the 5-stage F-D-E-M-WB pipeline.
- Selects the second ALU operand: register or sign-extended immediate.
- Performs one of four ALU operations.
- Registers the ALU result, store data and the forwarded control bits into the E/M pipeline register, which feeds the Memory stage.

---
 rtl/execute_stage.sv | 76 +++++++
 tb/tb_execute_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: operand-B mux, 4-op ALU, zero detect and the E/M register.
// All M-side outputs clear asynchronously when rst is low.
module execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] RD1_E,
  input  logic [WIDTH-1:0] RD2_E,
  input  logic [WIDTH-1:0] Extend_E,
  input  logic             Alu_src_E,
  input  logic [1:0]       Alu_op_E,
  input  logic             DM_Write_E,
  input  logic             Result_E,
  input  logic             RF_WE_E,
  output logic [WIDTH-1:0] Alu_out_M,
  output logic [WIDTH-1:0] WriteData_M,
  output logic             Zero_M,
  output logic             DM_Write_M,
  output logic             Result_M,
  output logic             RF_WE_M
);

  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_d;
  logic             zero_d;

  logic [WIDTH-1:0] alu_q;
  logic [WIDTH-1:0] wdata_q;
  logic             zero_q;
  logic             dm_we_q;
  logic             res_q;
  logic             rf_we_q;

  assign src_b = Alu_src_E ? Extend_E : RD2_E;

  always_comb begin
    alu_d = '0;
    unique case (Alu_op_E)
      2'b00: alu_d = RD1_E + src_b;
      2'b01: alu_d = RD1_E - src_b;
      2'b10: alu_d = RD1_E & src_b;
      2'b11: alu_d = RD1_E | src_b;
      default: alu_d = '0;
    endcase
  end

  assign zero_d = (alu_d == '0);

  // No stall/flush: the E/M register loads every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q   <= '0;
      wdata_q <= '0;
      zero_q  <= 1'b0;
      dm_we_q <= 1'b0;
      res_q   <= 1'b0;
      rf_we_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      wdata_q <= RD2_E;
      zero_q  <= zero_d;
      dm_we_q <= DM_Write_E;
      res_q   <= Result_E;
      rf_we_q <= RF_WE_E;
    end
  end

  assign Alu_out_M   = alu_q;
  assign WriteData_M = wdata_q;
  assign Zero_M      = zero_q;
  assign DM_Write_M  = dm_we_q;
  assign Result_M    = res_q;
  assign RF_WE_M     = rf_we_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed + random bench for execute_stage with an expected-result queue.
// Outputs are sampled 1 ns after the rising edge.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] RD1_E, RD2_E, Extend_E;
  logic        Alu_src_E;
  logic [1:0]  Alu_op_E;
  logic        DM_Write_E, Result_E, RF_WE_E;
  logic [31:0] Alu_out_M, WriteData_M;
  logic        Zero_M, DM_Write_M, Result_M, RF_WE_M;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic        zero;
    logic [2:0]  ctrl;
  } exp_t;

  exp_t sb[$];

  execute_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Extend_E(Extend_E),
    .Alu_src_E(Alu_src_E), .Alu_op_E(Alu_op_E),
    .DM_Write_E(DM_Write_E), .Result_E(Result_E), .RF_WE_E(RF_WE_E),
    .Alu_out_M(Alu_out_M), .WriteData_M(WriteData_M), .Zero_M(Zero_M),
    .DM_Write_M(DM_Write_M), .Result_M(Result_M), .RF_WE_M(RF_WE_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_all(input string tag);
    chk({tag, "_alu"}, Alu_out_M, 32'h0);
    chk({tag, "_wd"}, WriteData_M, 32'h0);
    chk({tag, "_zf"}, {31'h0, Zero_M}, 32'h0);
    chk({tag, "_ctl"}, {29'h0, DM_Write_M, Result_M, RF_WE_M}, 32'h0);
  endtask

  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [1:0] op);
    case (op)
      2'd0: return a + b;
      2'd1: return a + ~b + 32'd1;
      2'd2: return a & b;
      default: return a | b;
    endcase
  endfunction

  // Drive one E-side transaction, push its expectation, compare after the edge.
  task automatic step(input string tag, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ext,
                      input logic src, input logic [1:0] op,
                      input logic [2:0] ctl, input logic [31:0] exp_alu,
                      input logic exp_z);
    exp_t e;
    RD1_E = a; RD2_E = b; Extend_E = ext;
    Alu_src_E = src; Alu_op_E = op;
    {DM_Write_E, Result_E, RF_WE_E} = ctl;
    e.alu = exp_alu; e.wd = b; e.zero = exp_z; e.ctrl = ctl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_alu"}, Alu_out_M, e.alu);
      chk({tag, "_wd"}, WriteData_M, e.wd);
      chk({tag, "_zf"}, {31'h0, Zero_M}, {31'h0, e.zero});
      chk({tag, "_ctl"}, {29'h0, DM_Write_M, Result_M, RF_WE_M},
          {29'h0, e.ctrl});
    end
  endtask

  initial begin
    logic [31:0] a, b, x, r;
    logic [1:0]  op;
    logic        s;
    logic [2:0]  c;
    rst = 1'b0;
    RD1_E = 32'h0; RD2_E = 32'h0; Extend_E = 32'h0;
    Alu_src_E = 1'b0; Alu_op_E = 2'b00;
    DM_Write_E = 1'b0; Result_E = 1'b0; RF_WE_E = 1'b0;
    #20;
    chk_zero_all("reset_hold");
    rst = 1'b1;

    step("add_reg", 32'd4, 32'd5, 32'd6, 1'b0, 2'b00, 3'b000, 32'h9, 1'b0);
    step("sub_imm", 32'd4, 32'd5, 32'd6, 1'b1, 2'b01, 3'b000,
         32'hFFFF_FFFE, 1'b0);
    step("sub_eq", 32'd6, 32'd5, 32'd6, 1'b1, 2'b01, 3'b000, 32'h0, 1'b1);
    step("and_imm", 32'd4, 32'd5, 32'd6, 1'b1, 2'b10, 3'b000, 32'h4, 1'b0);
    step("or_imm", 32'd4, 32'd5, 32'd6, 1'b1, 2'b11, 3'b000, 32'h6, 1'b0);
    step("ctl_1a", 32'd1, 32'd2, 32'd0, 1'b0, 2'b00, 3'b111, 32'h3, 1'b0);
    step("ctl_0", 32'd1, 32'd2, 32'd0, 1'b0, 2'b00, 3'b000, 32'h3, 1'b0);
    step("ctl_1b", 32'd1, 32'd2, 32'd0, 1'b0, 2'b00, 3'b111, 32'h3, 1'b0);
    step("ctl_mix", 32'd1, 32'd2, 32'd0, 1'b0, 2'b00, 3'b101, 32'h3, 1'b0);
    step("ctl_mix2", 32'd1, 32'd2, 32'd0, 1'b0, 2'b00, 3'b010, 32'h3, 1'b0);
    step("wrap", 32'hFFFF_FFFF, 32'd1, 32'd7, 1'b0, 2'b00, 3'b000,
         32'h0, 1'b1);

    // Load something non-zero, then reset between edges.
    step("pre_rst", 32'hA5A5_0000, 32'h1234_5678, 32'h0000_5A5A, 1'b1,
         2'b11, 3'b111, 32'hA5A5_5A5A, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_zero_all("async_rst");
    @(posedge clk);
    #1;
    chk_zero_all("rst_held");
    rst = 1'b1;
    #1;
    chk_zero_all("rst_release");

    step("post_rst", 32'd10, 32'd3, 32'd0, 1'b0, 2'b01, 3'b110, 32'd7, 1'b0);

    for (int i = 0; i < 24; i++) begin
      a  = $urandom;
      b  = $urandom;
      x  = $urandom;
      op = 2'($urandom_range(0, 3));
      s  = 1'($urandom_range(0, 1));
      c  = 3'($urandom_range(0, 7));
      if (i % 6 == 0) b = a;
      if (i % 6 == 0) s = 1'b0;
      if (i % 6 == 0) op = 2'b01;
      r = model(a, s ? x : b, op);
      step("rand", a, b, x, s, op, c, r, r == 32'h0);
    end

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
